viterbi_decoder_k3: RTL and testbench

- Hard-decision Viterbi decoder for the team's rate-1/2, constraint-length-3 convolutional code (generators 7,5 octal).
- Sits directly downstream of the convolutional encoder, after the channel. Consumes one 2-bit parity symbol per accepted cycle and emits one decoded data bit per accepted symbol once its survivor window has filled.
- Uses a register-exchange survivor memory, so there is no traceback RAM.

---
 rtl/viterbi_decoder_k3.sv | 161 ++++++++++++++++
 tb/tb_viterbi_decoder_k3.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/viterbi_decoder_k3.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_decoder_k3
// Purpose  : Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5 octal)
//            convolutional code. The decoder keeps four path metrics and a
//            register-exchange survivor memory, and performs a single-cycle
//            add-compare-select for each accepted symbol.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK          in   1         rising-edge clock
//   RST          in   1         asynchronous active-high reset
//   clear        in   1         synchronous restart; it overrides in_valid
//   in_valid     in   1         parities is accepted on this rising edge
//   parities     in   2         received symbol {g7 bit, g5 bit}
//   out          out  1         decoded data bit
//   out_valid    out  1         one-cycle strobe that qualifies out
//   path_metric  out  PM_WIDTH  normalised metric of the runner-up state
// ============================================================================
module viterbi_decoder_k3 #(
  parameter int TB_DEPTH = 16,
  parameter int PM_WIDTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [1:0]          parities,
  output logic                out,
  output logic                out_valid,
  output logic [PM_WIDTH-1:0] path_metric
);

  localparam int                  c_cw       = $clog2(TB_DEPTH + 1);
  localparam logic [c_cw-1:0]     c_fill_max = c_cw'(TB_DEPTH);
  localparam logic [PM_WIDTH-1:0] c_pm_init  = PM_WIDTH'(4);

  // The survivor registers hold only TB_DEPTH-1 bits. The oldest bit of a
  // TB_DEPTH-bit survivor is shifted out by the same update that reads it,
  // so it only ever exists in the combinational new-survivor vector.
  logic [PM_WIDTH-1:0] pm_q [4];
  logic [PM_WIDTH-1:0] pm_d [4];
  logic [TB_DEPTH-2:0] sp_q [4];
  logic [TB_DEPTH-2:0] sp_d [4];
  logic [c_cw-1:0]     fill_q, fill_d;
  logic                out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [PM_WIDTH-1:0] metric_q, metric_d;

  logic [PM_WIDTH:0]   w_nm      [4];
  logic [TB_DEPTH-1:0] w_sp_new  [4];
  logic [PM_WIDTH-1:0] w_pm_norm [4];
  logic [PM_WIDTH:0]   w_min;
  logic [1:0]          w_best;
  logic [PM_WIDTH-1:0] w_second;

  // Add-compare-select for each next state ns = {b,a}. The predecessors are
  // {0,b} and {1,b}. Because c enters both code bits, the expected symbol
  // from predecessor {1,b} is the one from {0,b} with both bits inverted.
  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam int         c_a    = g & 1;
    localparam int         c_p0   = (g >> 1) & 1;
    localparam int         c_p1   = 2 + c_p0;
    localparam logic [1:0] c_exp0 = 2'((((c_a ^ c_p0) & 1) << 1) | c_a);
    localparam logic [1:0] c_exp1 = c_exp0 ^ 2'b11;

    logic [1:0]        w_x0, w_x1;
    logic [PM_WIDTH:0] w_cand0, w_cand1;
    logic              w_sel;

    assign w_x0    = parities ^ c_exp0;
    assign w_x1    = parities ^ c_exp1;
    assign w_cand0 = {1'b0, pm_q[c_p0]} + (PM_WIDTH+1)'(w_x0[1]) + (PM_WIDTH+1)'(w_x0[0]);
    assign w_cand1 = {1'b0, pm_q[c_p1]} + (PM_WIDTH+1)'(w_x1[1]) + (PM_WIDTH+1)'(w_x1[0]);
    // A tie keeps the {0,b} branch.
    assign w_sel   = (w_cand1 < w_cand0);
    assign w_nm[g] = w_sel ? w_cand1 : w_cand0;
    assign w_sp_new[g] = w_sel ? {sp_q[c_p1], 1'(c_a)} : {sp_q[c_p0], 1'(c_a)};
  end

  // Normalisation: subtract the smallest new metric so the best is always 0.
  always_comb begin
    w_min = w_nm[0];
    for (int i = 1; i < 4; i++) begin
      if (w_nm[i] < w_min) w_min = w_nm[i];
    end
    for (int i = 0; i < 4; i++) begin
      w_pm_norm[i] = PM_WIDTH'(w_nm[i] - w_min);
    end
  end

  // Lowest-index zero-metric state; scanning downwards leaves the lowest.
  always_comb begin
    w_best = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_pm_norm[i] == '0) w_best = 2'(i);
    end
  end

  // Runner-up metric: the minimum over every state except the chosen best,
  // so a second zero-metric state yields 0.
  always_comb begin
    w_second = '1;
    for (int i = 0; i < 4; i++) begin
      if ((2'(i) != w_best) && (w_pm_norm[i] < w_second)) w_second = w_pm_norm[i];
    end
  end

  always_comb begin
    pm_d        = pm_q;
    sp_d        = sp_q;
    fill_d      = fill_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    metric_d    = metric_q;
    if (clear) begin
      for (int i = 0; i < 4; i++) begin
        pm_d[i] = (i == 0) ? '0 : c_pm_init;
        sp_d[i] = '0;
      end
      fill_d   = '0;
      out_d    = 1'b0;
      metric_d = '0;
    end else if (in_valid) begin
      for (int i = 0; i < 4; i++) begin
        pm_d[i] = w_pm_norm[i];
        sp_d[i] = w_sp_new[i][TB_DEPTH-2:0];
      end
      fill_d      = (fill_q == c_fill_max) ? fill_q : fill_q + c_cw'(1);
      out_d       = w_sp_new[w_best][TB_DEPTH-1];
      metric_d    = w_second;
      out_valid_d = (fill_d == c_fill_max);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i] <= (i == 0) ? '0 : c_pm_init;
        sp_q[i] <= '0;
      end
      fill_q      <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      metric_q    <= '0;
    end else begin
      pm_q        <= pm_d;
      sp_q        <= sp_d;
      fill_q      <= fill_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      metric_q    <= metric_d;
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign path_metric = metric_q;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_decoder_k3.sv
`default_nettype none
// ============================================================================
// Module   : tb_viterbi_decoder_k3
// Purpose  : Directed self-checking bench for viterbi_decoder_k3 (TB_DEPTH=16,
//            PM_WIDTH=4): reset, fill latency, error-free and corrupted
//            streams, throttled input, synchronous clear and a random frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_viterbi_decoder_k3;

  localparam int TB_DEPTH = 16;
  localparam int PM_WIDTH = 4;

  logic                CLK = 1'b0;
  logic                RST;
  logic                clear;
  logic                in_valid;
  logic [1:0]          parities;
  logic                out;
  logic                out_valid;
  logic [PM_WIDTH-1:0] path_metric;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [1:0] stim     [0:127];
  logic       exp_bits [0:127];
  logic       data     [0:127];

  viterbi_decoder_k3 #(.TB_DEPTH(TB_DEPTH), .PM_WIDTH(PM_WIDTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .clear       (clear),
    .in_valid    (in_valid),
    .parities    (parities),
    .out         (out),
    .out_valid   (out_valid),
    .path_metric (path_metric)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Data 1,0,1,1,0,0 then zeros, encoded by hand from state 00.
  task automatic load_base();
    for (int i = 0; i < 128; i++) begin
      stim[i]     = 2'b00;
      exp_bits[i] = 1'b0;
    end
    stim[0] = 2'b11; stim[1] = 2'b10; stim[2] = 2'b00;
    stim[3] = 2'b01; stim[4] = 2'b01; stim[5] = 2'b11;
    exp_bits[0] = 1'b1; exp_bits[2] = 1'b1; exp_bits[3] = 1'b1;
  endtask

  task automatic do_clear(input string tag);
    clear    = 1'b1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    clear = 1'b0;
    check({tag, " out_valid"}, 8'(out_valid), 8'd0);
    check({tag, " out"}, 8'(out), 8'd0);
    check({tag, " path_metric"}, 8'(path_metric), 8'd0);
  endtask

  // Streams stim[0..n-1] starting from a restarted decoder, with `gap` idle
  // cycles after every accept. Decoded bit j appears on accept j+TB_DEPTH-1.
  task automatic run_stream(input string tag, input int n, input int gap, input bit pm_chk);
    logic last_out;
    int   nval;
    nval = 0;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      parities = stim[k];
      @(posedge CLK); #1;
      in_valid = 1'b0;
      check({tag, " out_valid"}, 8'(out_valid), 8'(k + 1 >= TB_DEPTH));
      if (k + 1 >= TB_DEPTH) begin
        check($sformatf("%s out[%0d]", tag, nval), 8'(out), 8'(exp_bits[nval]));
        nval++;
      end
      if (pm_chk) check({tag, " path_metric>=1"}, 8'(path_metric >= 4'd1), 8'd1);
      last_out = out;
      for (int g = 0; g < gap; g++) begin
        @(posedge CLK); #1;
        check({tag, " idle out_valid"}, 8'(out_valid), 8'd0);
        check({tag, " idle out hold"}, 8'(out), 8'(last_out));
      end
    end
  endtask

  initial begin
    logic eb, ec, a;

    // 1. Reset and fill latency
    RST = 1'b1; clear = 1'b0; in_valid = 1'b0; parities = 2'b00;
    #12;
    check("reset out", 8'(out), 8'd0);
    check("reset out_valid", 8'(out_valid), 8'd0);
    check("reset path_metric", 8'(path_metric), 8'd0);
    RST = 1'b0;
    for (int i = 0; i < 128; i++) begin
      stim[i] = 2'b00; exp_bits[i] = 1'b0;
    end
    run_stream("fill", 16, 0, 1'b1);

    // 2. Error-free stream, then asynchronous reset mid-cycle
    do_clear("clr2");
    load_base();
    run_stream("clean", 26, 0, 1'b1);
    check("clean steady path_metric", 8'(path_metric), 8'd2);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("async rst out_valid", 8'(out_valid), 8'd0);
    check("async rst out", 8'(out), 8'd0);
    check("async rst path_metric", 8'(path_metric), 8'd0);
    @(negedge CLK);
    RST = 1'b0;

    // 3. Single symbol error
    load_base();
    stim[2] = 2'b10;
    run_stream("err1", 26, 0, 1'b0);

    // 4. Two errors in adjacent symbols
    do_clear("clr4");
    load_base();
    stim[3] = 2'b00;
    stim[4] = 2'b11;
    run_stream("err2", 26, 0, 1'b0);

    // 5. Throttled input: one accept followed by two idle cycles
    do_clear("clr5");
    load_base();
    run_stream("gap", 26, 2, 1'b1);

    // 6. clear together with in_valid on the 10th symbol
    do_clear("clr6");
    load_base();
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1;
      parities = stim[k];
      @(posedge CLK); #1;
      check("pre-clear out_valid", 8'(out_valid), 8'd0);
    end
    clear    = 1'b1;
    in_valid = 1'b1;
    parities = stim[9];
    @(posedge CLK); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear out_valid", 8'(out_valid), 8'd0);
    check("clear out", 8'(out), 8'd0);
    check("clear path_metric", 8'(path_metric), 8'd0);
    check("clear pm0", 8'(dut.pm_q[0]), 8'd0);
    check("clear pm1", 8'(dut.pm_q[1]), 8'd4);
    check("clear pm2", 8'(dut.pm_q[2]), 8'd4);
    check("clear pm3", 8'(dut.pm_q[3]), 8'd4);
    for (int i = 0; i < 16; i++) stim[i] = stim[10 + i];
    for (int i = 0; i < 16; i++) exp_bits[i] = 1'b0;
    run_stream("post-clear", 16, 0, 1'b1);

    // 7. Random frame with one flipped bit every 8 symbols
    do_clear("clr7");
    eb = 1'b0; ec = 1'b0;
    for (int k = 0; k < 82; k++) begin
      data[k] = (k < 64) ? 1'($urandom_range(1, 0)) : 1'b0;
      a = data[k];
      stim[k] = {a ^ eb ^ ec, a ^ ec};
      ec = eb;
      eb = a;
      if (k < 64 && (k % 8) == 3) stim[k] = stim[k] ^ (((k % 16) == 3) ? 2'b10 : 2'b01);
      exp_bits[k] = data[k];
    end
    run_stream("random", 82, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
